attosoc_ram_arbiter: RTL and testbench

//  Two-master arbiter for the SoC's single-port 32-bit RAM (sync read, 1-cycle latency, byte write strobes).

---
 rtl/attosoc_ram_arbiter.sv | 95 +++++++++
 tb/tb_attosoc_ram_arbiter.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/attosoc_ram_arbiter.sv
// Two-master arbiter for the single-port 32-bit SoC RAM (sync read, 1-cycle latency).
// Each access takes a grant cycle (IDLE) followed by a response cycle (RESP).
module attosoc_ram_arbiter #(
  parameter int ADDR_WIDTH = 14,
  parameter int FIXED_PRIO = 0
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  m0_valid,
  input  logic [31:0]           m0_addr,
  input  logic [31:0]           m0_wdata,
  input  logic [3:0]            m0_wstrb,
  output logic                  m0_ready,
  output logic [31:0]           m0_rdata,
  input  logic                  m1_valid,
  input  logic [31:0]           m1_addr,
  input  logic [31:0]           m1_wdata,
  input  logic [3:0]            m1_wstrb,
  output logic                  m1_ready,
  output logic [31:0]           m1_rdata,
  output logic                  ram_en,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [3:0]            ram_wstrb,
  output logic [31:0]           ram_wdata,
  input  logic [31:0]           ram_rdata,
  output logic [1:0]            grant
);

  // state | meaning
  // IDLE  | arbitrate; the winner's access is driven onto the RAM port this cycle
  // RESP  | RAM read data returns; the owner's ready pulses for one cycle
  typedef enum logic {IDLE, RESP} state_t;

  state_t state;
  logic   last;
  logic   win_m1;
  logic   any_valid;
  logic   m0_rdy_q;
  logic   m1_rdy_q;
  logic   unused_addr_bits;

  assign any_valid = m0_valid | m1_valid;

  // last holds the previous winner; under round-robin the other master wins a contest
  always_comb begin
    win_m1 = 1'b0;
    if (m1_valid && !m0_valid) begin
      win_m1 = 1'b1;
    end else if (m1_valid && m0_valid && FIXED_PRIO == 0) begin
      win_m1 = ~last;
    end
  end

  assign ram_en    = resetn & (state == IDLE) & any_valid;
  assign ram_addr  = win_m1 ? m1_addr[ADDR_WIDTH+1:2] : m0_addr[ADDR_WIDTH+1:2];
  assign ram_wstrb = win_m1 ? m1_wstrb : m0_wstrb;
  assign ram_wdata = win_m1 ? m1_wdata : m0_wdata;

  assign m0_rdata = ram_rdata;
  assign m1_rdata = ram_rdata;

  // ready comes only from flops, so there is no path from valid to ready
  assign m0_ready = m0_rdy_q & resetn;
  assign m1_ready = m1_rdy_q & resetn;

  assign unused_addr_bits = ^{m0_addr[31:ADDR_WIDTH+2], m0_addr[1:0],
                              m1_addr[31:ADDR_WIDTH+2], m1_addr[1:0]};

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state    <= IDLE;
      last     <= 1'b1;
      grant    <= 2'b00;
      m0_rdy_q <= 1'b0;
      m1_rdy_q <= 1'b0;
    end else begin
      m0_rdy_q <= 1'b0;
      m1_rdy_q <= 1'b0;
      case (state)
        IDLE: begin
          if (any_valid) begin
            last     <= win_m1;
            grant    <= win_m1 ? 2'b10 : 2'b01;
            m0_rdy_q <= ~win_m1;
            m1_rdy_q <= win_m1;
            state    <= RESP;
          end
        end
        RESP: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_attosoc_ram_arbiter.sv
// Bench for attosoc_ram_arbiter: directed scenarios plus a randomized two-master run
// checked against a transaction-level model of arbitration order and RAM contents.
module tb_attosoc_ram_arbiter;
  localparam int AW = 14;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          resetn;
  logic          m0_valid, m1_valid;
  logic [31:0]   m0_addr, m1_addr, m0_wdata, m1_wdata;
  logic [3:0]    m0_wstrb, m1_wstrb;
  logic          m0_ready, m1_ready;
  logic [31:0]   m0_rdata, m1_rdata;
  logic          ram_en;
  logic [AW-1:0] ram_addr;
  logic [3:0]    ram_wstrb;
  logic [31:0]   ram_wdata, ram_rdata;
  logic [1:0]    grant;

  logic          f_m0_valid, f_m1_valid;
  logic [31:0]   f_m0_addr, f_m1_addr, f_wdata;
  logic [3:0]    f_wstrb;
  logic          f_m0_ready, f_m1_ready;
  logic [31:0]   f_m0_rdata_unused, f_m1_rdata_unused;
  logic          f_ram_en;
  logic [AW-1:0] f_ram_addr;
  logic [3:0]    f_ram_wstrb_unused;
  logic [31:0]   f_ram_wdata_unused;
  logic [31:0]   f_ram_rdata;
  logic [1:0]    f_grant;

  logic [31:0] mem       [1<<AW];
  logic [31:0] model_mem [1<<AW];

  int errors = 0;
  int checks = 0;

  attosoc_ram_arbiter #(.ADDR_WIDTH(AW), .FIXED_PRIO(0)) dut (
    .clk(clk), .resetn(resetn),
    .m0_valid(m0_valid), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb),
    .m0_ready(m0_ready), .m0_rdata(m0_rdata),
    .m1_valid(m1_valid), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb),
    .m1_ready(m1_ready), .m1_rdata(m1_rdata),
    .ram_en(ram_en), .ram_addr(ram_addr), .ram_wstrb(ram_wstrb), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .grant(grant)
  );

  attosoc_ram_arbiter #(.ADDR_WIDTH(AW), .FIXED_PRIO(1)) dut_fp (
    .clk(clk), .resetn(resetn),
    .m0_valid(f_m0_valid), .m0_addr(f_m0_addr), .m0_wdata(f_wdata), .m0_wstrb(f_wstrb),
    .m0_ready(f_m0_ready), .m0_rdata(f_m0_rdata_unused),
    .m1_valid(f_m1_valid), .m1_addr(f_m1_addr), .m1_wdata(f_wdata), .m1_wstrb(f_wstrb),
    .m1_ready(f_m1_ready), .m1_rdata(f_m1_rdata_unused),
    .ram_en(f_ram_en), .ram_addr(f_ram_addr), .ram_wstrb(f_ram_wstrb_unused),
    .ram_wdata(f_ram_wdata_unused), .ram_rdata(f_ram_rdata), .grant(f_grant)
  );

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] s);
    logic [31:0] mask;
    mask = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
    return (old & ~mask) | (nw & mask);
  endfunction

  // RAM array behind the arbiter: synchronous read, byte-enabled write
  always @(posedge clk) begin
    if (ram_en) begin
      mem[ram_addr] <= merge(mem[ram_addr], ram_wdata, ram_wstrb);
      ram_rdata     <= mem[ram_addr];
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_m(input int m, input logic v, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] s);
    if (m == 0) begin
      m0_valid = v; m0_addr = a; m0_wdata = d; m0_wstrb = s;
    end else begin
      m1_valid = v; m1_addr = a; m1_wdata = d; m1_wstrb = s;
    end
  endtask

  task automatic do_reset();
    set_m(0, 1'b0, 32'h0, 32'h0, 4'h0);
    set_m(1, 1'b0, 32'h0, 32'h0, 4'h0);
    f_m0_valid = 1'b0;
    f_m1_valid = 1'b0;
    resetn = 1'b0;
    tick();
    tick();
    resetn = 1'b1;
  endtask

  task automatic test_reset();
    resetn = 1'b1;
    set_m(0, 1'b0, 32'h0, 32'h0, 4'h0);
    set_m(1, 1'b0, 32'h0, 32'h0, 4'h0);
    #2;
    resetn = 1'b0;
    m0_valid = 1'b1;
    m1_valid = 1'b1;
    #2;
    checks++; if (m0_ready !== 1'b0) begin errors++; $display("FAIL reset_m0_ready got=%b want=0", m0_ready); end
    checks++; if (m1_ready !== 1'b0) begin errors++; $display("FAIL reset_m1_ready got=%b want=0", m1_ready); end
    checks++; if (ram_en !== 1'b0) begin errors++; $display("FAIL reset_ram_en got=%b want=0", ram_en); end
    checks++; if (grant !== 2'b00) begin errors++; $display("FAIL reset_grant got=%b want=00", grant); end
    tick();
    @(negedge clk);
    checks++; if (ram_en !== 1'b0) begin errors++; $display("FAIL reset_ram_en_clocked got=%b want=0", ram_en); end
    m0_valid = 1'b0;
    m1_valid = 1'b0;
    tick();
    resetn = 1'b1;
  endtask

  task automatic test_read();
    do_reset();
    set_m(0, 1'b1, 32'h10, 32'h0, 4'h0);
    @(negedge clk);
    checks++; if (ram_en !== 1'b1) begin errors++; $display("FAIL read_ram_en got=%b want=1", ram_en); end
    checks++; if (ram_addr !== 14'd4) begin errors++; $display("FAIL read_ram_addr got=%0d want=4", ram_addr); end
    checks++; if (m0_ready !== 1'b0) begin errors++; $display("FAIL read_ready_early got=%b want=0", m0_ready); end
    tick();
    @(negedge clk);
    checks++; if (m0_ready !== 1'b1) begin errors++; $display("FAIL read_m0_ready got=%b want=1", m0_ready); end
    checks++; if (m0_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL read_m0_rdata got=%h want=deadbeef", m0_rdata); end
    checks++; if (ram_en !== 1'b0) begin errors++; $display("FAIL read_resp_ram_en got=%b want=0", ram_en); end
    checks++; if (grant !== 2'b01) begin errors++; $display("FAIL read_grant got=%b want=01", grant); end
    tick();
    set_m(0, 1'b0, 32'h0, 32'h0, 4'h0);
  endtask

  task automatic test_write_readback();
    logic [31:0] exp;
    exp = merge(model_mem[8], 32'h11223344, 4'b0101);
    model_mem[8] = exp;
    set_m(1, 1'b1, 32'h20, 32'h11223344, 4'b0101);
    @(negedge clk);
    checks++; if (ram_en !== 1'b1 || ram_addr !== 14'd8) begin errors++; $display("FAIL write_issue en=%b addr=%0d want en=1 addr=8", ram_en, ram_addr); end
    checks++; if (ram_wstrb !== 4'b0101) begin errors++; $display("FAIL write_wstrb got=%b want=0101", ram_wstrb); end
    checks++; if (ram_wdata !== 32'h11223344) begin errors++; $display("FAIL write_wdata got=%h want=11223344", ram_wdata); end
    tick();
    @(negedge clk);
    checks++; if (m1_ready !== 1'b1 || m0_ready !== 1'b0) begin errors++; $display("FAIL write_ready m1=%b m0=%b want m1=1 m0=0", m1_ready, m0_ready); end
    tick();
    set_m(1, 1'b1, 32'h20, 32'h0, 4'h0);
    @(negedge clk);
    checks++; if (ram_en !== 1'b1) begin errors++; $display("FAIL readback_ram_en got=%b want=1", ram_en); end
    tick();
    @(negedge clk);
    checks++; if (m1_ready !== 1'b1 || m1_rdata !== exp) begin errors++; $display("FAIL readback_data ready=%b got=%h want=%h", m1_ready, m1_rdata, exp); end
    checks++; if (mem[8] !== exp) begin errors++; $display("FAIL write_ram_word got=%h want=%h", mem[8], exp); end
    tick();
    set_m(1, 1'b0, 32'h0, 32'h0, 4'h0);
  endtask

  task automatic test_round_robin();
    logic [AW-1:0] ea;
    logic [31:0]   rd;
    do_reset();
    set_m(0, 1'b1, 32'h40, 32'h0, 4'h0);
    set_m(1, 1'b1, 32'h80, 32'h0, 4'h0);
    for (int k = 0; k < 8; k++) begin
      ea = (k % 2 == 1) ? 14'd32 : 14'd16;
      @(negedge clk);
      checks++; if (ram_en !== 1'b1 || ram_addr !== ea) begin errors++; $display("FAIL rr_issue_%0d en=%b addr=%0d want addr=%0d", k, ram_en, ram_addr, ea); end
      tick();
      @(negedge clk);
      rd = (k % 2 == 1) ? m1_rdata : m0_rdata;
      checks++; if (grant !== ((k % 2 == 1) ? 2'b10 : 2'b01)) begin errors++; $display("FAIL rr_grant_%0d got=%b", k, grant); end
      checks++; if (m0_ready !== (k % 2 == 0) || m1_ready !== (k % 2 == 1)) begin errors++; $display("FAIL rr_ready_%0d m0=%b m1=%b", k, m0_ready, m1_ready); end
      checks++; if (rd !== model_mem[ea]) begin errors++; $display("FAIL rr_rdata_%0d got=%h want=%h", k, rd, model_mem[ea]); end
      tick();
    end
    set_m(0, 1'b0, 32'h0, 32'h0, 4'h0);
    set_m(1, 1'b0, 32'h0, 32'h0, 4'h0);
  endtask

  task automatic test_fixed_prio();
    do_reset();
    f_wdata = 32'h0;
    f_wstrb = 4'h0;
    f_m0_valid = 1'b1; f_m0_addr = 32'h44;
    f_m1_valid = 1'b1; f_m1_addr = 32'h88;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      if (k % 2 == 0) begin
        checks++; if (f_ram_en !== 1'b1 || f_ram_addr !== 14'd17) begin errors++; $display("FAIL fp_issue_%0d en=%b addr=%0d want en=1 addr=17", k, f_ram_en, f_ram_addr); end
      end else begin
        checks++; if (f_m0_ready !== 1'b1 || f_grant !== 2'b01) begin errors++; $display("FAIL fp_resp_%0d m0_ready=%b grant=%b want 1/01", k, f_m0_ready, f_grant); end
      end
      checks++; if (f_m1_ready !== 1'b0) begin errors++; $display("FAIL fp_m1_ready_%0d got=%b want=0", k, f_m1_ready); end
      tick();
    end
    f_m0_valid = 1'b0;
    f_m1_valid = 1'b0;
  endtask

  task automatic test_reset_in_resp();
    do_reset();
    model_mem[12] = 32'hA5A55A5A;
    set_m(0, 1'b1, 32'h30, 32'hA5A55A5A, 4'hF);
    @(negedge clk);
    checks++; if (ram_en !== 1'b1 || ram_addr !== 14'd12) begin errors++; $display("FAIL rresp_issue en=%b addr=%0d want en=1 addr=12", ram_en, ram_addr); end
    tick();
    checks++; if (m0_ready !== 1'b1) begin errors++; $display("FAIL rresp_pre_ready got=%b want=1", m0_ready); end
    #1;
    resetn = 1'b0;
    #1;
    checks++; if (m0_ready !== 1'b0 || m1_ready !== 1'b0) begin errors++; $display("FAIL rresp_ready_gated m0=%b m1=%b want 0/0", m0_ready, m1_ready); end
    set_m(0, 1'b0, 32'h0, 32'h0, 4'h0);
    tick();
    resetn = 1'b1;
    set_m(0, 1'b1, 32'h30, 32'h0, 4'h0);
    @(negedge clk);
    checks++; if (ram_en !== 1'b1) begin errors++; $display("FAIL rresp_idle_after got=%b want=1", ram_en); end
    tick();
    @(negedge clk);
    checks++; if (m0_ready !== 1'b1 || m0_rdata !== 32'hA5A55A5A) begin errors++; $display("FAIL rresp_write_kept ready=%b got=%h want=a5a55a5a", m0_ready, m0_rdata); end
    tick();
    set_m(0, 1'b0, 32'h0, 32'h0, 4'h0);
  endtask

  task automatic test_wrap();
    set_m(0, 1'b1, 32'h0001_0004, 32'h0, 4'h0);
    @(negedge clk);
    checks++; if (ram_en !== 1'b1 || ram_addr !== 14'd1) begin errors++; $display("FAIL wrap_addr en=%b got=%0d want=1", ram_en, ram_addr); end
    tick();
    @(negedge clk);
    checks++; if (m0_ready !== 1'b1 || m0_rdata !== model_mem[1]) begin errors++; $display("FAIL wrap_rdata ready=%b got=%h want=%h", m0_ready, m0_rdata, model_mem[1]); end
    tick();
    set_m(0, 1'b0, 32'h0, 32'h0, 4'h0);
  endtask

  task automatic test_drop_valid();
    set_m(1, 1'b1, 32'h0C, 32'h0, 4'h0);
    @(negedge clk);
    checks++; if (ram_en !== 1'b1 || ram_addr !== 14'd3) begin errors++; $display("FAIL drop_issue en=%b addr=%0d want en=1 addr=3", ram_en, ram_addr); end
    tick();
    m1_valid = 1'b0;
    @(negedge clk);
    checks++; if (m1_ready !== 1'b1 || m1_rdata !== model_mem[3]) begin errors++; $display("FAIL drop_ready ready=%b got=%h want=%h", m1_ready, m1_rdata, model_mem[3]); end
    tick();
    @(negedge clk);
    checks++; if (ram_en !== 1'b0 || m1_ready !== 1'b0) begin errors++; $display("FAIL drop_quiet en=%b ready=%b want 0/0", ram_en, m1_ready); end
    tick();
  endtask

  task automatic test_random();
    logic          act [2];
    logic [31:0]   ra  [2];
    logic [31:0]   rd  [2];
    logic [3:0]    rs  [2];
    logic          busy, exp_read, rdy_own, rdy_oth;
    int            win, own, last;
    logic [AW-1:0] idx;
    logic [31:0]   exp_rd, got_rd;
    do_reset();
    act[0] = 1'b0; act[1] = 1'b0;
    busy = 1'b0; exp_read = 1'b0; own = 0; last = 1; exp_rd = 32'h0;
    for (int c = 0; c < 300; c++) begin
      for (int m = 0; m < 2; m++) begin
        if (!act[m] && $urandom_range(0, 2) != 0) begin
          act[m] = 1'b1;
          ra[m]  = ($urandom & 32'hFFFF_0000) | (32'($urandom_range(0, 63)) << 2) | 32'($urandom_range(0, 3));
          rs[m]  = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'h0;
          rd[m]  = $urandom;
        end
      end
      set_m(0, act[0], ra[0], rd[0], rs[0]);
      set_m(1, act[1], ra[1], rd[1], rs[1]);
      @(negedge clk);
      if (!busy) begin
        if (act[0] || act[1]) begin
          win = (act[0] && act[1]) ? ((last == 0) ? 1 : 0) : (act[1] ? 1 : 0);
          idx = AW'(ra[win] >> 2);
          checks++; if (ram_en !== 1'b1 || ram_addr !== idx) begin errors++; $display("FAIL rnd_issue_c%0d en=%b addr=%0d want addr=%0d (m%0d)", c, ram_en, ram_addr, idx, win); end
          checks++; if (ram_wstrb !== rs[win]) begin errors++; $display("FAIL rnd_wstrb_c%0d got=%b want=%b", c, ram_wstrb, rs[win]); end
          if (rs[win] != 4'h0) begin
            checks++; if (ram_wdata !== rd[win]) begin errors++; $display("FAIL rnd_wdata_c%0d got=%h want=%h", c, ram_wdata, rd[win]); end
          end
          checks++; if (m0_ready !== 1'b0 || m1_ready !== 1'b0) begin errors++; $display("FAIL rnd_grant_ready_c%0d m0=%b m1=%b want 0/0", c, m0_ready, m1_ready); end
          exp_rd = model_mem[idx];
          model_mem[idx] = merge(exp_rd, rd[win], rs[win]);
          exp_read = (rs[win] == 4'h0);
          busy = 1'b1; own = win; last = win;
        end else begin
          checks++; if (ram_en !== 1'b0 || m0_ready !== 1'b0 || m1_ready !== 1'b0) begin errors++; $display("FAIL rnd_idle_c%0d en=%b m0=%b m1=%b want 0/0/0", c, ram_en, m0_ready, m1_ready); end
        end
      end else begin
        rdy_own = (own == 0) ? m0_ready : m1_ready;
        rdy_oth = (own == 0) ? m1_ready : m0_ready;
        got_rd  = (own == 0) ? m0_rdata : m1_rdata;
        checks++; if (ram_en !== 1'b0 || rdy_own !== 1'b1 || rdy_oth !== 1'b0) begin errors++; $display("FAIL rnd_resp_c%0d en=%b owner_ready=%b other_ready=%b want 0/1/0", c, ram_en, rdy_own, rdy_oth); end
        checks++; if (grant !== ((own == 1) ? 2'b10 : 2'b01)) begin errors++; $display("FAIL rnd_grant_c%0d got=%b owner=m%0d", c, grant, own); end
        if (exp_read) begin
          checks++; if (got_rd !== exp_rd) begin errors++; $display("FAIL rnd_rdata_c%0d got=%h want=%h", c, got_rd, exp_rd); end
        end
        busy = 1'b0;
        act[own] = 1'b0;
      end
      tick();
    end
    set_m(0, 1'b0, 32'h0, 32'h0, 4'h0);
    set_m(1, 1'b0, 32'h0, 32'h0, 4'h0);
    tick();
    tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < (1 << AW); i++) begin
      mem[i]       = 32'(i) * 32'h0101_0101 ^ 32'h5A5A_0000;
      model_mem[i] = 32'(i) * 32'h0101_0101 ^ 32'h5A5A_0000;
    end
    mem[4]       = 32'hDEADBEEF;
    model_mem[4] = 32'hDEADBEEF;
    f_m0_valid = 1'b0; f_m1_valid = 1'b0;
    f_m0_addr = 32'h0; f_m1_addr = 32'h0;
    f_wdata = 32'h0; f_wstrb = 4'h0; f_ram_rdata = 32'h0;

    test_reset();
    test_read();
    test_write_readback();
    test_round_robin();
    test_fixed_prio();
    test_reset_in_resp();
    test_wrap();
    test_drop_valid();
    test_random();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
